l2_request_responder: RTL

Responder end of the L1-to-next-level command interface. It accepts the 26-bit line address and 2-bit command that an L1 cache drives toward the next level, buffers requests in a small FIFO, and models a fixed next-level access latency. It returns a one-cycle completion pulse that echoes the address and command. It sits between the L1 instruction/data caches and the statistics module, and optionally keeps its own request counters.

---
 rtl/l2_request_responder_if.sv | 19 +
 rtl/l2_request_responder.sv | 126 ++++++++++++
 2 files changed

// File: rtl/l2_request_responder_if.sv
// Command/response bundle between an L1 cache (master) and the next-level responder (slave).
interface l2_request_responder_if;
    logic [1:0]  cmd_in;
    logic [25:0] add_in;
    logic        req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_cmd;
    logic [25:0] rsp_add;

    modport master (
        output cmd_in, add_in,
        input  req_ready, rsp_valid, rsp_cmd, rsp_add
    );

    modport slave (
        input  cmd_in, add_in,
        output req_ready, rsp_valid, rsp_cmd, rsp_add
    );
endinterface

// File: rtl/l2_request_responder.sv
// Next-level responder: FIFO-buffered L1 requests served after a fixed latency, echoed as a one-cycle pulse.
// Define L2_RESPONDER_STATS_EN to build the reads/writes/dropped counters; otherwise they read 0.
module l2_request_responder #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    l2_request_responder_if.slave       bus,
    output logic [31:0]                 reads,
    output logic [31:0]                 writes,
    output logic [31:0]                 dropped
);
    localparam int               AW         = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [3:0]       CNT_LOAD   = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_next;
    logic [3:0]    cnt, cnt_next;
    logic [27:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [1:0]    svc_cmd;
    logic [25:0]   svc_add;
    logic          push, pop;

    // No pass-through: a full FIFO refuses a push even when a pop occurs at the same edge.
    assign bus.req_ready = (count != FULL_COUNT);
    assign push          = (bus.cmd_in != 2'b00) && bus.req_ready;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_next = RESP;
                else             cnt_next   = cnt - 4'd1;
            end
            RESP: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = WAIT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.cmd_in, bus.add_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Service registers stay stable through WAIT, so the response stage can latch them on entry to RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            svc_cmd       <= 2'b00;
            svc_add       <= 26'd0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_cmd   <= 2'b00;
            bus.rsp_add   <= 26'd0;
        end else begin
            if (pop) {svc_cmd, svc_add} <= mem[rd_ptr];
            bus.rsp_valid <= (state_next == RESP);
            bus.rsp_cmd   <= (state_next == RESP) ? svc_cmd : 2'b00;
            bus.rsp_add   <= (state_next == RESP) ? svc_add : 26'd0;
        end
    end

`ifdef L2_RESPONDER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reads   <= 32'd0;
            writes  <= 32'd0;
            dropped <= 32'd0;
        end else begin
            if (push && (bus.cmd_in == 2'b01 || bus.cmd_in == 2'b11)) reads <= reads + 32'd1;
            if (push && bus.cmd_in == 2'b10) writes <= writes + 32'd1;
            if (bus.cmd_in != 2'b00 && !bus.req_ready) dropped <= dropped + 32'd1;
        end
    end
`else
    assign reads   = 32'h0;
    assign writes  = 32'h0;
    assign dropped = 32'h0;
`endif

endmodule
